// File: rtl/fbw_arbiter.sv
// Two-port frame-buffer write arbiter with frame-granular ownership.
// A port keeps the interface from grant until it swaps a frame, drops its request,
// or the idle watchdog forces a release. Tie-break is round-robin by default;
// defining FBW_ARB_FIXED_PRIO_EN gives port 0 fixed priority on ties.
module fbw_arbiter #(
  parameter int unsigned TIMEOUT = 65535,
  parameter int unsigned TW      = 16
) (
  input  logic        clk,
  input  logic        rst,
  // Requester port 0
  input  logic        req_0,
  input  logic [5:0]  fbw_row_addr_0,
  input  logic        fbw_row_store_0,
  input  logic        fbw_row_swap_0,
  input  logic [23:0] fbw_data_0,
  input  logic [5:0]  fbw_col_addr_0,
  input  logic        fbw_wren_0,
  input  logic        frame_swap_0,
  output logic        fbw_row_rdy_0,
  output logic        frame_rdy_0,
  // Requester port 1
  input  logic        req_1,
  input  logic [5:0]  fbw_row_addr_1,
  input  logic        fbw_row_store_1,
  input  logic        fbw_row_swap_1,
  input  logic [23:0] fbw_data_1,
  input  logic [5:0]  fbw_col_addr_1,
  input  logic        fbw_wren_1,
  input  logic        frame_swap_1,
  output logic        fbw_row_rdy_1,
  output logic        frame_rdy_1,
  // Frame-buffer side
  output logic [5:0]  fbw_row_addr,
  output logic        fbw_row_store,
  output logic        fbw_row_swap,
  output logic [23:0] fbw_data,
  output logic [5:0]  fbw_col_addr,
  output logic        fbw_wren,
  output logic        frame_swap,
  input  logic        fbw_row_rdy,
  input  logic        frame_rdy,
  // Status
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  localparam logic [TW-1:0] TimeoutVal = TW'(TIMEOUT);

  state_e        state_q;
  logic [1:0]    grant_q;
  logic          last_grant_q;  // 1 = port 1 owned the last completed frame
  logic [TW-1:0] wdog_q;
  logic          timeout_err_q;

  logic pick;       // 1 selects port 1 when leaving idle
  logic owner;      // index of the current owner
  logic owner_req;
  logic owner_act;
  logic wdog_hit;

`ifdef FBW_ARB_FIXED_PRIO_EN
  assign pick = ~req_0;
`else
  assign pick = (req_0 && req_1) ? ~last_grant_q : req_1;
`endif

  assign owner     = grant_q[1];
  assign owner_req = grant_q[1] ? req_1 : req_0;
  // Muxed strobes only ever come from the owner, so they double as owner activity.
  assign owner_act = fbw_wren | fbw_row_store | fbw_row_swap | frame_swap;
  assign wdog_hit  = (TIMEOUT != 0) && ((wdog_q + 1'b1) == TimeoutVal);

  assign grant         = grant_q;
  assign timeout_err   = timeout_err_q;
  assign fbw_row_rdy_0 = fbw_row_rdy & grant_q[0];
  assign fbw_row_rdy_1 = fbw_row_rdy & grant_q[1];
  assign frame_rdy_0   = frame_rdy & grant_q[0];
  assign frame_rdy_1   = frame_rdy & grant_q[1];

  // Forward the owner's write interface; everything is zero with no owner.
  always_comb begin
    fbw_row_addr  = '0;
    fbw_row_store = 1'b0;
    fbw_row_swap  = 1'b0;
    fbw_data      = '0;
    fbw_col_addr  = '0;
    fbw_wren      = 1'b0;
    frame_swap    = 1'b0;
    if (grant_q[0]) begin
      fbw_row_addr  = fbw_row_addr_0;
      fbw_row_store = fbw_row_store_0;
      fbw_row_swap  = fbw_row_swap_0;
      fbw_data      = fbw_data_0;
      fbw_col_addr  = fbw_col_addr_0;
      fbw_wren      = fbw_wren_0;
      frame_swap    = frame_swap_0;
    end else if (grant_q[1]) begin
      fbw_row_addr  = fbw_row_addr_1;
      fbw_row_store = fbw_row_store_1;
      fbw_row_swap  = fbw_row_swap_1;
      fbw_data      = fbw_data_1;
      fbw_col_addr  = fbw_col_addr_1;
      fbw_wren      = fbw_wren_1;
      frame_swap    = frame_swap_1;
    end
  end

  // Ownership FSM with watchdog; grant and timeout_err are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      grant_q       <= 2'b00;
      last_grant_q  <= 1'b1;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (frame_rdy && (req_0 || req_1)) begin
            grant_q <= pick ? 2'b10 : 2'b01;
            wdog_q  <= '0;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (frame_swap) begin
            // A swap wins over a simultaneous timeout.
            last_grant_q <= owner;
            grant_q      <= 2'b00;
            state_q      <= StRelease;
          end else if (!owner_req) begin
            grant_q <= 2'b00;
            state_q <= StRelease;
          end else if (owner_act) begin
            wdog_q <= '0;
          end else if (wdog_hit) begin
            // Forced release favours the other port on the next tie.
            last_grant_q  <= owner;
            grant_q       <= 2'b00;
            timeout_err_q <= 1'b1;
            wdog_q        <= '0;
            state_q       <= StRelease;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        StRelease: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fbw_arbiter.sv
// Self-checking bench for fbw_arbiter: a per-cycle vector table plus directed
// sequences for frame_rdy hold-off, a full 64-row frame, watchdog release and
// mid-frame reset. Expectations follow FBW_ARB_FIXED_PRIO_EN when defined.
module tb_fbw_arbiter;

  localparam int unsigned Timeout = 100;

  localparam logic [23:0] D0  = 24'h111111;
  localparam logic [23:0] D1  = 24'h222222;
  localparam logic [5:0]  Ra0 = 6'd5;
  localparam logic [5:0]  Ra1 = 6'd9;
  localparam logic [5:0]  Ca0 = 6'd3;
  localparam logic [5:0]  Ca1 = 6'd7;

`ifdef FBW_ARB_FIXED_PRIO_EN
  localparam logic [1:0] TieA = 2'b01;
  localparam logic [1:0] TieB = 2'b01;
`else
  localparam logic [1:0] TieA = 2'b10;
  localparam logic [1:0] TieB = 2'b01;
`endif

  logic        clk, rst;
  logic        req_0, req_1;
  logic [5:0]  fbw_row_addr_0, fbw_row_addr_1, fbw_col_addr_0, fbw_col_addr_1;
  logic        fbw_row_store_0, fbw_row_store_1, fbw_row_swap_0, fbw_row_swap_1;
  logic [23:0] fbw_data_0, fbw_data_1;
  logic        fbw_wren_0, fbw_wren_1, frame_swap_0, frame_swap_1;
  logic        fbw_row_rdy_0, fbw_row_rdy_1, frame_rdy_0, frame_rdy_1;
  logic [5:0]  fbw_row_addr, fbw_col_addr;
  logic        fbw_row_store, fbw_row_swap, fbw_wren, frame_swap;
  logic [23:0] fbw_data;
  logic        fbw_row_rdy, frame_rdy;
  logic [1:0]  grant;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  fbw_arbiter #(.TIMEOUT(Timeout), .TW(16)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .fbw_row_addr_0(fbw_row_addr_0), .fbw_row_store_0(fbw_row_store_0),
    .fbw_row_swap_0(fbw_row_swap_0), .fbw_data_0(fbw_data_0),
    .fbw_col_addr_0(fbw_col_addr_0), .fbw_wren_0(fbw_wren_0),
    .frame_swap_0(frame_swap_0), .fbw_row_rdy_0(fbw_row_rdy_0), .frame_rdy_0(frame_rdy_0),
    .req_1(req_1), .fbw_row_addr_1(fbw_row_addr_1), .fbw_row_store_1(fbw_row_store_1),
    .fbw_row_swap_1(fbw_row_swap_1), .fbw_data_1(fbw_data_1),
    .fbw_col_addr_1(fbw_col_addr_1), .fbw_wren_1(fbw_wren_1),
    .frame_swap_1(frame_swap_1), .fbw_row_rdy_1(fbw_row_rdy_1), .frame_rdy_1(frame_rdy_1),
    .fbw_row_addr(fbw_row_addr), .fbw_row_store(fbw_row_store),
    .fbw_row_swap(fbw_row_swap), .fbw_data(fbw_data), .fbw_col_addr(fbw_col_addr),
    .fbw_wren(fbw_wren), .frame_swap(frame_swap),
    .fbw_row_rdy(fbw_row_rdy), .frame_rdy(frame_rdy),
    .grant(grant), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       req0, req1, frdy, rrdy, wren0, wren1, fs0, fs1;
    logic [1:0] grant;
    logic       terr;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(input logic r0, input logic r1, input logic fr, input logic rr,
                              input logic w0, input logic w1, input logic f0, input logic f1,
                              input logic [1:0] g);
    vec_t v;
    v.req0 = r0; v.req1 = r1; v.frdy = fr; v.rrdy = rr;
    v.wren0 = w0; v.wren1 = w1; v.fs0 = f0; v.fs1 = f1;
    v.grant = g; v.terr = 1'b0;
    return v;
  endfunction

  // Observed output bundle, zero-extended to 64 bits.
  function automatic logic [63:0] obs();
    return {17'b0, grant, timeout_err, fbw_wren, frame_swap, fbw_row_store, fbw_row_swap,
            fbw_data, fbw_row_addr, fbw_col_addr,
            fbw_row_rdy_0, fbw_row_rdy_1, frame_rdy_0, frame_rdy_1};
  endfunction

  // Expected bundle for a table row (row strobes are held low in the table).
  function automatic logic [63:0] model(input vec_t v);
    logic g0, g1, w, f;
    logic [23:0] d;
    logic [5:0] ra, ca;
    g0 = v.grant[0];
    g1 = v.grant[1];
    w  = g0 ? v.wren0 : (g1 ? v.wren1 : 1'b0);
    f  = g0 ? v.fs0 : (g1 ? v.fs1 : 1'b0);
    d  = g0 ? D0 : (g1 ? D1 : 24'h0);
    ra = g0 ? Ra0 : (g1 ? Ra1 : 6'd0);
    ca = g0 ? Ca0 : (g1 ? Ca1 : 6'd0);
    return {17'b0, v.grant, v.terr, w, f, 1'b0, 1'b0, d, ra, ca,
            v.rrdy & g0, v.rrdy & g1, v.frdy & g0, v.frdy & g1};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req_0 = 0; req_1 = 0; frame_rdy = 0; fbw_row_rdy = 0;
    fbw_row_store_0 = 0; fbw_row_store_1 = 0; fbw_row_swap_0 = 0; fbw_row_swap_1 = 0;
    fbw_wren_0 = 0; fbw_wren_1 = 0; frame_swap_0 = 0; frame_swap_1 = 0;
    fbw_data_0 = D0; fbw_data_1 = D1; fbw_row_addr_0 = Ra0; fbw_row_addr_1 = Ra1;
    fbw_col_addr_0 = Ca0; fbw_col_addr_1 = Ca1;
  endtask

  task automatic apply(input vec_t v);
    req_0 = v.req0; req_1 = v.req1; frame_rdy = v.frdy; fbw_row_rdy = v.rrdy;
    fbw_wren_0 = v.wren0; fbw_wren_1 = v.wren1; frame_swap_0 = v.fs0; frame_swap_1 = v.fs1;
  endtask

  initial begin
    int bad;
    int gcyc, tcyc;
    logic [1:0] gown, g_at_t, g_next;
    logic terr_after, fs_seen, found;

    // Reset stimulus / expectation table: one row per cycle.
    vecs[0]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 2'b00);
    vecs[1]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 2'b00);  // request sampled here
    vecs[2]  = mk(1, 0, 1, 0, 1, 0, 0, 0, 2'b01);  // one-cycle grant latency
    vecs[3]  = mk(1, 0, 1, 0, 0, 1, 0, 0, 2'b01);  // port 1 wren dropped
    vecs[4]  = mk(1, 0, 1, 1, 1, 1, 0, 0, 2'b01);  // only owner sees row_rdy
    vecs[5]  = mk(1, 0, 1, 0, 0, 0, 1, 0, 2'b01);  // swap forwarded same cycle
    vecs[6]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 2'b00);  // release
    vecs[7]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 2'b00);  // idle, tie sampled
    vecs[8]  = mk(1, 1, 1, 0, 0, 0, 1, 1, TieA);
    vecs[9]  = mk(1, 1, 1, 0, 0, 0, 1, 1, 2'b00);
    vecs[10] = mk(1, 1, 1, 0, 0, 0, 1, 1, 2'b00);
    vecs[11] = mk(1, 1, 1, 0, 0, 0, 1, 1, TieB);
    vecs[12] = mk(1, 1, 1, 0, 0, 0, 1, 1, 2'b00);
    vecs[13] = mk(1, 1, 1, 0, 0, 0, 1, 1, 2'b00);
    vecs[14] = mk(1, 1, 1, 0, 0, 0, 1, 1, TieA);
    vecs[15] = mk(1, 1, 1, 0, 0, 0, 1, 1, 2'b00);
    vecs[16] = mk(1, 1, 1, 0, 0, 0, 1, 1, 2'b00);
    vecs[17] = mk(1, 1, 1, 0, 0, 0, 1, 1, TieB);
    vecs[18] = mk(1, 1, 1, 0, 0, 0, 1, 1, 2'b00);
    vecs[19] = mk(0, 0, 1, 0, 0, 0, 0, 0, 2'b00);

    // Reset with busy inputs: everything downstream must stay low.
    clear_inputs();
    rst = 1'b1;
    req_0 = 1; req_1 = 1; frame_rdy = 1; fbw_row_rdy = 1; fbw_wren_0 = 1; frame_swap_1 = 1;
    repeat (2) @(posedge clk);
    #2;
    check("reset_state", obs(), 64'h0);
    #1;
    clear_inputs();
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      apply(vecs[i]);
      #1;
      check($sformatf("vec%0d", i), obs(), model(vecs[i]));
    end

    // frame_rdy low holds off a pending request.
    clear_inputs();
    req_0 = 1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (grant !== 2'b00) bad++;
    end
    check("frdy_low_hold", 64'(bad), 64'd0);
    #1 frame_rdy = 1;
    #1 check("frdy_rise_same_cycle", {62'b0, grant}, 64'b00);
    @(posedge clk);
    #2 check("frdy_rise_grant", {62'b0, grant}, 64'b01);

    // Port 0 writes 64 rows while port 1 toggles its strobes.
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      #1;
      fbw_row_addr_0 = 6'(i); fbw_row_store_0 = 1; fbw_wren_0 = (i % 2) == 0;
      fbw_wren_1 = (i % 2) != 0; fbw_row_store_1 = 1;
      #1;
      if ({grant, fbw_row_store, fbw_row_addr, fbw_wren, fbw_row_rdy_1, frame_rdy_1} !==
          {2'b01, 1'b1, 6'(i), fbw_wren_0, 1'b0, 1'b0}) bad++;
      @(posedge clk);
    end
    check("rows_64", 64'(bad), 64'd0);
    #1;
    fbw_row_store_0 = 0; fbw_wren_0 = 0; fbw_row_store_1 = 0; fbw_wren_1 = 0;
    frame_swap_0 = 1;
    #1 check("frame_swap_fwd", {62'b0, grant, frame_swap}, {61'b0, 2'b01, 1'b1});
    @(posedge clk);
    #1 frame_swap_0 = 0;
    #1 check("release_cycle", {62'b0, grant}, 64'b00);
    @(posedge clk);
    #2 check("idle_after_release", {62'b0, grant}, 64'b00);
    @(posedge clk);
    #2 check("regrant_after_release", {62'b0, grant}, 64'b01);

    // Owner drops its request without swapping.
    #1 req_0 = 0;
    @(posedge clk);
    @(posedge clk);
    #1 req_0 = 1; req_1 = 1;

    // Owner idles until the watchdog fires.
    gcyc = -1; tcyc = -1; fs_seen = 0; gown = 2'b00;
    g_at_t = 2'b11; g_next = 2'b11; terr_after = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #2;
      if (gcyc < 0 && grant != 2'b00) begin gcyc = c; gown = grant; end
      if (frame_swap) fs_seen = 1;
      if (tcyc < 0 && timeout_err) begin tcyc = c; g_at_t = grant; end
      if (tcyc >= 0 && c == tcyc + 1) terr_after = timeout_err;
      if (tcyc >= 0 && c == tcyc + 2) begin g_next = grant; break; end
    end
    check("wd_owner", {62'b0, gown}, {62'b0, TieA});
    check("wd_latency", 64'(tcyc - gcyc), 64'(Timeout));
    check("wd_grant_cleared", {62'b0, g_at_t}, 64'b00);
    check("wd_pulse_width", {63'b0, terr_after}, 64'b0);
    check("wd_no_swap", {63'b0, fs_seen}, 64'b0);
    check("wd_next_tie", {62'b0, g_next}, {62'b0, TieB});

    // Hand the buffer to port 1, then reset mid-row.
    #1 frame_swap_0 = 1;
    @(posedge clk);
    #1 frame_swap_0 = 0; req_0 = 0;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #2;
      if (grant == 2'b10) begin found = 1; break; end
    end
    check("port1_granted", {63'b0, found}, 64'd1);
    #1 fbw_row_store_1 = 1; fbw_wren_1 = 1; fbw_row_rdy = 1;
    #1 check("port1_mid_row", {63'b0, fbw_row_store}, 64'd1);
    #1 rst = 1'b1;
    #1 check("async_reset_outputs", obs(), 64'h0);
    #3 rst = 1'b0;
    clear_inputs();
    req_0 = 1; frame_rdy = 1;
    @(posedge clk);
    #2 check("post_reset_grant", {62'b0, grant, 1'b0, frame_swap, fbw_row_store} >> 1,
             {62'b0, 2'b01, 1'b0, 1'b0, 1'b0} >> 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
